// File: rtl/msg_channel_arbiter.sv
// msg_channel_arbiter: round-robin share of one NIB_W-bit message channel
// between a single-nibble requester (A) and a B_BEATS-nibble burst requester (B).
//
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   a_req/a_data/a_ack    A request level, nibble, one-cycle capture pulse
//   b_req/b_data/b_ack    B request level, burst (nibble 0 in LSBs), capture pulse
//   ch_valid/ch_ready     channel beat handshake
//   ch_data/ch_last       current beat and final-beat flag
//   ch_src                source of current message (0 = A, 1 = B)
//   busy                  high when not IDLE
//   a_msg_cnt/b_msg_cnt   completed-message counters (only with MSG_ARB_STATS_EN)
//
// Optional feature macro: MSG_ARB_STATS_EN adds the per-source message counters.
module msg_channel_arbiter #(
    parameter int NIB_W   = 4,
    parameter int B_BEATS = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     a_req,
    input  logic [NIB_W-1:0]         a_data,
    output logic                     a_ack,
    input  logic                     b_req,
    input  logic [B_BEATS*NIB_W-1:0] b_data,
    output logic                     b_ack,
    output logic                     ch_valid,
    input  logic                     ch_ready,
    output logic [NIB_W-1:0]         ch_data,
    output logic                     ch_last,
    output logic                     ch_src,
    output logic                     busy
`ifdef MSG_ARB_STATS_EN
    ,
    output logic [7:0]               a_msg_cnt,
    output logic [7:0]               b_msg_cnt
`endif
);

    localparam int BW = B_BEATS * NIB_W;
    localparam int CW = $clog2(B_BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(B_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            last_grant, last_grant_nxt;
    logic [BW-1:0]   shreg, shreg_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic            a_ack_nxt, b_ack_nxt;
    logic            valid_nxt, last_nxt, src_nxt;
    logic [NIB_W-1:0] data_nxt;
    logic            grant_a, grant_b, hs;

    assign hs      = ch_valid & ch_ready;
    assign cnt_inc = cnt + CW'(1);

    // last_grant: 0 = A, 1 = B; the requester that did not win last time
    // takes a tie.
    assign grant_a = a_req & (~b_req | last_grant);
    assign grant_b = b_req & ~grant_a;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            shreg      <= '0;
            cnt        <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            ch_valid   <= 1'b0;
            ch_data    <= '0;
            ch_last    <= 1'b0;
            ch_src     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            shreg      <= shreg_nxt;
            cnt        <= cnt_nxt;
            a_ack      <= a_ack_nxt;
            b_ack      <= b_ack_nxt;
            ch_valid   <= valid_nxt;
            ch_data    <= data_nxt;
            ch_last    <= last_nxt;
            ch_src     <= src_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        shreg_nxt      = shreg;
        cnt_nxt        = cnt;
        a_ack_nxt      = 1'b0;
        b_ack_nxt      = 1'b0;
        valid_nxt      = ch_valid;
        data_nxt       = ch_data;
        last_nxt       = ch_last;
        src_nxt        = ch_src;
        unique case (state)
            IDLE: begin
                if (grant_a) begin
                    state_nxt      = SEND_A;
                    last_grant_nxt = 1'b0;
                    a_ack_nxt      = 1'b1;
                    valid_nxt      = 1'b1;
                    data_nxt       = a_data;
                    last_nxt       = 1'b1;
                    src_nxt        = 1'b0;
                end else if (grant_b) begin
                    state_nxt      = SEND_B;
                    last_grant_nxt = 1'b1;
                    b_ack_nxt      = 1'b1;
                    shreg_nxt      = b_data;
                    cnt_nxt        = '0;
                    valid_nxt      = 1'b1;
                    data_nxt       = b_data[NIB_W-1:0];
                    last_nxt       = 1'b0;
                    src_nxt        = 1'b1;
                end
            end
            SEND_A: begin
                if (hs) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                end
            end
            SEND_B: begin
                if (hs) begin
                    if (cnt == LAST_BEAT) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                    end else begin
                        // Next beat comes from the nibble above the one
                        // currently on the channel.
                        shreg_nxt = shreg >> NIB_W;
                        cnt_nxt   = cnt_inc;
                        data_nxt  = shreg[2*NIB_W-1:NIB_W];
                        last_nxt  = (cnt_inc == LAST_BEAT);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

`ifdef MSG_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_msg_cnt <= '0;
            b_msg_cnt <= '0;
        end else begin
            if (hs && state == SEND_A)
                a_msg_cnt <= a_msg_cnt + 8'd1;
            if (hs && state == SEND_B && cnt == LAST_BEAT)
                b_msg_cnt <= b_msg_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/msg_channel_arbiter.md
Name: msg_channel_arbiter

Overview:
- Shares one NIB_W-bit message channel between two requesters.
- Requester A sends single-nibble messages. Requester B sends B_BEATS-nibble burst messages.
- Grants the channel round-robin, latches the winner's message, serialises it onto the channel with a valid/ready handshake, and never interleaves beats of different messages.
- Sits between the random-message generators and the message sink in the A/B message-exchange subsystem.

Parameters:
- NIB_W, 4, width of one message nibble / channel beat.
- B_BEATS, 4, nibbles per B message (>=2); b_data is B_BEATS*NIB_W bits wide.

Ports:
- clock  in  1  rising-edge clock; sole clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  A has a message; level, held with a_data stable until a_ack.
- a_data  in  NIB_W  A message nibble.
- a_ack  out  1  one-cycle pulse: A message captured.
- b_req  in  1  B has a message; level, held with b_data stable until b_ack.
- b_data  in  B_BEATS*NIB_W  B message; nibble 0 = bits [NIB_W-1:0], sent first.
- b_ack  out  1  one-cycle pulse: B message captured.
- ch_valid  out  1  channel beat valid.
- ch_ready  in  1  sink accepts the beat when high with ch_valid.
- ch_data  out  NIB_W  current beat.
- ch_last  out  1  high on the final beat of a message (always high for A).
- ch_src  out  1  source of the current message: 0 = A, 1 = B.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset values: a_ack, b_ack, ch_valid, ch_data, ch_last, ch_src, busy all 0. State IDLE, beat counter 0, last_grant = B, so A wins the first tie.
- All outputs are registered.
- States: IDLE, SEND_A, SEND_B.
- IDLE:
  - Only a_req: latch a_data, go to SEND_A, a_ack=1 for the next cycle.
  - Only b_req: latch b_data into the shift register, go to SEND_B, b_ack=1 for the next cycle.
  - Both: grant the requester not equal to last_grant.
  - last_grant is updated on every grant.
- SEND_A:
  - ch_valid=1, ch_data=latched nibble, ch_last=1, ch_src=0.
  - On ch_valid&&ch_ready, go to IDLE; ch_valid drops the following cycle.
- SEND_B:
  - ch_valid=1, ch_src=1, ch_data=shift register low nibble, beat counter starts at 0.
  - Each ch_ready handshake shifts right by NIB_W and increments the counter.
  - ch_last=1 when counter==B_BEATS-1; a handshake on that beat goes to IDLE.
- ch_ready low holds ch_data, ch_last and ch_src stable. Backpressure is unbounded; there is no timeout.
- Latency:
  - Request sampled in IDLE at edge N: ack and first ch_valid at N+1.
  - A one-cycle IDLE bubble always follows the last handshake, so the minimum message period is beats+1 cycles.
- Requests arriving during SEND are ignored until IDLE.
- A requester must deassert req, or present new data, in the cycle after its ack. If req is still high in IDLE, a new message is captured, so a continuously held req yields repeated messages.
- a_ack and b_ack are never high together.
- A req dropped before grant is never acked.
- Asynchronous reset mid-message: all registers return to reset values immediately. The in-flight message is discarded, no further beats are sent, and no ack is reissued.

Optional Feature:
- MSG_ARB_STATS_EN defined:
  - Adds outputs a_msg_cnt [7:0] and b_msg_cnt [7:0], reset 0.
  - Each counter increments by 1 on the final-beat handshake of a message from that source, wrapping 255->0.
- MSG_ARB_STATS_EN undefined: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- a_req=1, a_data=4'hA, ch_ready=1 -> a_ack pulse 1 cycle after request; one beat ch_data=A, ch_last=1, ch_src=0; busy then 0.
- b_req=1, b_data=16'h4321, ch_ready=1 -> b_ack pulse; beats 1,2,3,4 on consecutive cycles; ch_last only on beat 4; ch_src=1 throughout.
- a_req and b_req both held high from reset for 20 cycles -> grant order A,B,A,B; every grant preceded by a 1-cycle IDLE bubble; never two acks in one cycle.
- B burst 16'h8765 with ch_ready low on beat 2 for 3 cycles -> ch_data=6 held stable; sequence 5,6,7,8 intact; a_req raised mid-burst is not granted until after beat 8.
- reset_n pulled low during beat 2 of a B burst -> ch_valid=0 immediately; after release, IDLE with no stale beats; a subsequent A request wins the tie (last_grant=B).
- With MSG_ARB_STATS_EN: 300 A messages -> a_msg_cnt=44 (wrapped), b_msg_cnt=0.
